// File: rtl/keypress_event_gen.sv
// keypress_event_gen: turns HID keycode samples into new-press events queued in a FIFO
module keypress_event_gen #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] keycode,
  input  logic        keycode_valid,
  output logic        busy,
  output logic        event_valid,
  output logic [7:0]  event_code,
  input  logic        event_ready,
  output logic [4:0]  fifo_count,
  output logic        overflow,
  input  logic        overflow_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;
  logic [31:0] prev, sample;
  logic [3:0] mask, new_mask;
  logic [1:0] lane;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic rollover, push, pop, full, push_ok;
  logic [7:0] lane_code;
  // a lane is new if nonzero, absent from prev, and not a repeat of a lower lane
  always_comb begin
    new_mask = '0;
    rollover = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rollover = rollover | (keycode[8*i +: 8] == 8'h01);
      new_mask[i] = keycode[8*i +: 8] != 8'h00;
      for (int j = 0; j < 4; j++) if (keycode[8*i +: 8] == prev[8*j +: 8]) new_mask[i] = 1'b0;
      for (int j = 0; j < i; j++) if (keycode[8*i +: 8] == keycode[8*j +: 8]) new_mask[i] = 1'b0;
    end
  end
  assign lane_code   = sample[{lane, 3'b000} +: 8];
  assign push        = (state == SCAN) && mask[lane];
  assign event_valid = fifo_count != 5'd0;
  assign pop         = event_valid && event_ready;
  assign full        = fifo_count == DEPTH;
  assign push_ok     = push && (!full || pop);
  assign busy        = state == SCAN;
  assign event_code  = event_valid ? mem[rd_ptr] : 8'h00;
  always_ff @(posedge clk) if (!reset && push_ok) mem[wr_ptr] <= lane_code;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      sample     <= '0;
      mask       <= '0;
      lane       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + 5'(push_ok) - 5'(pop);
      overflow   <= (push && full && !pop) || (overflow && !overflow_clr);
      if (state == IDLE) begin
        if (keycode_valid && !rollover) begin
          prev   <= keycode;
          sample <= keycode;
          mask   <= new_mask;
          lane   <= 2'd0;
          state  <= SCAN;
        end
      end else begin
        lane <= lane + 2'd1;
        if (lane == 2'd3) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_keypress_event_gen.sv
// tb_keypress_event_gen: scoreboard bench for keypress_event_gen with directed samples
module tb_keypress_event_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] keycode = '0;
  logic keycode_valid = 1'b0;
  logic busy, event_valid, overflow;
  logic [7:0] event_code;
  logic event_ready = 1'b1;
  logic [4:0] fifo_count;
  logic overflow_clr = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  keypress_event_gen #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .keycode(keycode), .keycode_valid(keycode_valid),
    .busy(busy), .event_valid(event_valid), .event_code(event_code),
    .event_ready(event_ready), .fifo_count(fifo_count), .overflow(overflow),
    .overflow_clr(overflow_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  // every accepted event must match the oldest expected code
  always @(negedge clk) begin
    if (!reset && event_valid && event_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%0h required=none", event_code);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("event_code", {24'h0, event_code}, {24'h0, e});
      end
    end
  end
  task automatic strobe(input logic [31:0] k, input int n, input logic [31:0] e, input int exp_busy);
    int bc;
    for (int i = 0; i < n; i++) exp_q.push_back(e[8*i +: 8]);
    keycode = k;
    keycode_valid = 1'b1;
    @(posedge clk);
    #1 keycode_valid = 1'b0;
    bc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
    end
    check("busy_cycles", bc, exp_busy);
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && fifo_count != 5'd0; i++) @(negedge clk);
    check("drain_count", {27'h0, fifo_count}, 32'd0);
  endtask
  task automatic check_reset_outputs();
    check("rst_event_valid", {31'h0, event_valid}, 32'd0);
    check("rst_event_code", {24'h0, event_code}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_fifo_count", {27'h0, fifo_count}, 32'd0);
    check("rst_overflow", {31'h0, overflow}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    strobe(32'h00000004, 1, 32'h04, 4);
    drain();
    strobe(32'h00000504, 1, 32'h05, 4);
    drain();
    strobe(32'h00000500, 0, 32'h0, 4);
    strobe(32'h00000000, 0, 32'h0, 4);
    drain();
    strobe(32'h04040404, 1, 32'h04, 4);
    drain();
    strobe(32'h01010101, 0, 32'h0, 0);
    strobe(32'h00000004, 0, 32'h0, 4);
    drain();
    event_ready = 1'b0;
    strobe(32'h13121110, 4, 32'h13121110, 4);
    strobe(32'h17161514, 4, 32'h17161514, 4);
    strobe(32'h1B1A1918, 0, 32'h0, 4);
    check("ovf_count", {27'h0, fifo_count}, 32'd8);
    check("ovf_flag", {31'h0, overflow}, 32'd1);
    check("ovf_head", {24'h0, event_code}, 32'h10);
    overflow_clr = 1'b1;
    @(posedge clk);
    #1 overflow_clr = 1'b0;
    check("ovf_cleared", {31'h0, overflow}, 32'd0);
    check("ovf_count_kept", {27'h0, fifo_count}, 32'd8);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h1C + 8'(i));
    keycode = 32'h1F1E1D1C;
    keycode_valid = 1'b1;
    @(posedge clk);
    #1 keycode_valid = 1'b0;
    event_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 event_ready = 1'b0;
    check("full_pop_count", {27'h0, fifo_count}, 32'd8);
    check("full_pop_overflow", {31'h0, overflow}, 32'd0);
    check("full_pop_busy", {31'h0, busy}, 32'd0);
    check("full_pop_head", {24'h0, event_code}, 32'h14);
    event_ready = 1'b1;
    drain();
    event_ready = 1'b0;
    keycode = 32'h07060504;
    keycode_valid = 1'b1;
    @(posedge clk);
    #1 keycode_valid = 1'b0;
    @(posedge clk);
    #1 check("mid_lane0_valid", {31'h0, event_valid}, 32'd1);
    check("mid_lane0_code", {24'h0, event_code}, 32'h04);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (5) @(negedge clk);
    check("mid_no_more_push", {27'h0, fifo_count}, 32'd0);
    event_ready = 1'b1;
    strobe(32'h00000004, 1, 32'h04, 4);
    drain();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
